// File: rtl/inst_encoder_if.sv
// Request/response bundle between an instruction source and inst_encoder.
// The encoder side uses the slave modport; the source/loader side uses master.
`ifndef WORD
`define WORD 64
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif

interface inst_encoder_if;
   logic                    clear;
   logic                    in_valid;
   logic                    in_ready;
   logic [10:0]             in_op;
   logic [4:0]              in_rd;
   logic [4:0]              in_rn;
   logic [4:0]              in_rm;
   logic [`WORD-1:0]        in_imm;
   logic                    out_valid;
   logic                    out_ready;
   logic [`WORD-1:0]        out_addr;
   logic [`INST_SIZE-1:0]   out_inst;
   logic                    err;
   logic [7:0]              err_cnt;

   modport master (
      output clear, in_valid, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
      input  in_ready, out_valid, out_addr, out_inst, err, err_cnt
   );

   modport slave (
      input  clear, in_valid, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
      output in_ready, out_valid, out_addr, out_inst, err, err_cnt
   );
endinterface

// File: rtl/inst_encoder.sv
// LEGv8 instruction encoder: packs op/register/immediate fields into a 32-bit word and streams (addr, inst).
// Optional INST_ENC_RANGE_CHECK_EN enables immediate range checking with a sticky error and a saturating drop count.
`ifndef WORD
`define WORD 64
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif
`ifndef LSL
`define LSL   11'b11010011011
`define LSR   11'b11010011010
`define ADDI  11'b1001000100?
`define ANDI  11'b1001001000?
`define EORI  11'b1101001000?
`define ORRI  11'b1011001000?
`define SUBI  11'b1101000100?
`define SUBIS 11'b1111000100?
`define LDUR  11'b11111000010
`define STUR  11'b11111000000
`define CBZ   11'b10110100???
`define CBNZ  11'b10110101???
`define BCOND 11'b01010100???
`define B     11'b000101?????
`define BL    11'b100101?????
`define MOVK  11'b111100101??
`define MOVZ  11'b110100101??
`endif

module inst_encoder #(
   parameter logic [`WORD-1:0] BASE_ADDR = 64'h0,
   parameter int               ADDR_STEP = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   inst_encoder_if.slave bus
);

   typedef enum logic {IDLE, EMIT} state_e;

   state_e                state_q, state_d;
   logic [`INST_SIZE-1:0] out_inst_q, out_inst_d, enc_inst;
   logic [`WORD-1:0]      out_addr_q, out_addr_d;
   logic                  err_q, err_d;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic                  range_ok;

   // Field packing; ops outside the immediate classes encode as R-type.
   always_comb begin
      enc_inst = {bus.in_op, bus.in_rm, 6'd0, bus.in_rn, bus.in_rd};
      casez (bus.in_op)
         `LSL, `LSR:
            enc_inst = {bus.in_op, bus.in_rm, bus.in_imm[5:0], bus.in_rn, bus.in_rd};
         `ADDI, `ANDI, `EORI, `ORRI, `SUBI, `SUBIS:
            enc_inst = {bus.in_op, bus.in_imm[10:0], bus.in_rn, bus.in_rd};
         `LDUR, `STUR:
            enc_inst = {bus.in_op, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
         `CBZ, `CBNZ, `BCOND, `MOVK, `MOVZ:
            enc_inst = {bus.in_op, bus.in_imm[15:0], bus.in_rd};
         `B, `BL:
            enc_inst = {bus.in_op[10:5], bus.in_imm[25:0]};
         default: ;
      endcase
   end

`ifdef INST_ENC_RANGE_CHECK_EN
   // Signed fit: every bit from w-1 upward is a copy of the sign.
   function automatic logic fits_s(input logic [63:0] v, input int unsigned w);
      logic [63:0] t;
      t = $signed(v) >>> (w - 1);
      return (&t) | (~|t);
   endfunction

   function automatic logic fits_u(input logic [63:0] v, input int unsigned w);
      return (v >> w) == 64'd0;
   endfunction

   always_comb begin
      range_ok = 1'b1;
      casez (bus.in_op)
         `LSL, `LSR:                                 range_ok = fits_u(bus.in_imm, 6);
         `ADDI, `ANDI, `EORI, `ORRI, `SUBI, `SUBIS: range_ok = fits_s(bus.in_imm, 11);
         `LDUR, `STUR:                               range_ok = fits_s(bus.in_imm, 9);
         `CBZ, `CBNZ, `BCOND:                        range_ok = fits_s(bus.in_imm, 16);
         `B, `BL:                                    range_ok = fits_s(bus.in_imm, 21);
         `MOVK, `MOVZ:                               range_ok = fits_u(bus.in_imm, 16);
         default:                                    range_ok = 1'b1;
      endcase
   end
`else
   assign range_ok = 1'b1;
`endif

   // clear overrides everything, including a pending word in EMIT.
   always_comb begin
      state_d    = state_q;
      out_inst_d = out_inst_q;
      out_addr_d = out_addr_q;
      err_d      = err_q;
      err_cnt_d  = err_cnt_q;
      if (bus.clear) begin
         state_d    = IDLE;
         out_addr_d = BASE_ADDR;
         err_d      = 1'b0;
         err_cnt_d  = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  if (range_ok) begin
                     out_inst_d = enc_inst;
                     state_d    = EMIT;
                  end else begin
                     err_d = 1'b1;
                     if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                  end
               end
            end
            EMIT: begin
               if (bus.out_ready) begin
                  out_addr_d = out_addr_q + `WORD'(ADDR_STEP);
                  state_d    = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         out_inst_q <= '0;
         out_addr_q <= BASE_ADDR;
         err_q      <= 1'b0;
         err_cnt_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         out_inst_q <= out_inst_d;
         out_addr_q <= out_addr_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !bus.clear;
   assign bus.out_valid = (state_q == EMIT);
   assign bus.out_addr  = out_addr_q;
   assign bus.out_inst  = out_inst_q;
   assign bus.err       = err_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized scoreboard bench for inst_encoder with a transaction-level encoding model.
// Follows INST_ENC_RANGE_CHECK_EN the same way the design does.
module tb_inst_encoder;
   localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FF00;
   localparam int STEP = 4;
   localparam int C_R = 0, C_SH = 1, C_ALUI = 2, C_MEM = 3, C_CB = 4, C_BR = 5, C_MOV = 6;
`ifdef INST_ENC_RANGE_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inst_encoder_if bus();
   inst_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // ADD SUB AND LSL LSR ADDI ANDI EORI ORRI SUBI SUBIS LDUR STUR CBZ CBNZ BCOND B BL MOVK MOVZ
   logic [10:0] op_base [20] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
      11'b11010011011, 11'b11010011010, 11'b10010001000, 11'b10010010000, 11'b11010010000,
      11'b10110010000, 11'b11010001000, 11'b11110001000, 11'b11111000010, 11'b11111000000,
      11'b10110100000, 11'b10110101000, 11'b01010100000, 11'b00010100000, 11'b10010100000,
      11'b11110010100, 11'b11010010100};
   int op_cls [20] = '{C_R, C_R, C_R, C_SH, C_SH, C_ALUI, C_ALUI, C_ALUI, C_ALUI, C_ALUI,
      C_ALUI, C_MEM, C_MEM, C_CB, C_CB, C_CB, C_BR, C_BR, C_MOV, C_MOV};

   typedef struct { logic [63:0] addr; logic [31:0] inst; } exp_t;
   exp_t sb_q[$];

   int checks = 0;
   int errors = 0;
   int rdy_mode = 2;   // 0 random, 1 held low, 2 held high
   logic [63:0] m_addr = BASE;
   bit m_err = 1'b0;
   int m_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void cls_range(input int cls, output int w, output bit sgn, output bit chk);
      chk = 1'b1; sgn = 1'b1; w = 0;
      case (cls)
         C_SH:    begin w = 6;  sgn = 1'b0; end
         C_ALUI:  w = 11;
         C_MEM:   w = 9;
         C_CB:    w = 16;
         C_BR:    w = 21;
         C_MOV:   begin w = 16; sgn = 1'b0; end
         default: chk = 1'b0;
      endcase
   endfunction

   function automatic void model(input int cls, input logic [10:0] op, input logic [4:0] rd,
                                 input logic [4:0] rn, input logic [4:0] rm, input logic [63:0] imm,
                                 output logic [31:0] inst, output bit fits);
      longint unsigned o, d, n, m, iu, r;
      longint si, lim;
      int w; bit sgn, chk;
      o = 64'(op); d = 64'(rd); n = 64'(rn); m = 64'(rm); iu = imm; si = imm;
      case (cls)
         C_SH:   r = o * 2**21 + m * 2**16 + (iu % 64) * 2**10 + n * 32 + d;
         C_ALUI: r = o * 2**21 + (iu % 2048) * 2**10 + n * 32 + d;
         C_MEM:  r = o * 2**21 + (iu % 512) * 2**12 + n * 32 + d;
         C_CB, C_MOV: r = o * 2**21 + (iu % 65536) * 32 + d;
         C_BR:   r = (o / 32) * 2**26 + (iu % 2**26);
         default: r = o * 2**21 + m * 2**16 + n * 32 + d;
      endcase
      inst = r[31:0];
      cls_range(cls, w, sgn, chk);
      lim = longint'(1) <<< (sgn ? w - 1 : w);
      if (!chk)     fits = 1'b1;
      else if (sgn) fits = (si >= -lim) && (si < lim);
      else          fits = iu < 64'(lim);
   endfunction

   function automatic logic [63:0] pick_imm(input int cls);
      int w; bit sgn, chk;
      longint lo, hi;
      cls_range(cls, w, sgn, chk);
      if (!chk) return {$urandom, $urandom};
      if (sgn) begin lo = -(longint'(1) <<< (w - 1)); hi = (longint'(1) <<< (w - 1)) - 1; end
      else     begin lo = 0; hi = (longint'(1) <<< w) - 1; end
      case ($urandom_range(0, 5))
         0: return hi;
         1: return lo;
         2: return hi + 1;
         3: return lo - 1;
         4: return lo + longint'($urandom) % (hi - lo + 1);
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic send(input int idx, input logic [63:0] imm, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm);
      int n = 0;
      logic [10:0] op;
      logic [31:0] inst;
      bit fits;
      op = op_base[idx];
      if (op_cls[idx] == C_ALUI) op[0] = 1'($urandom);
      if (op_cls[idx] == C_CB || op_cls[idx] == C_MOV) op[1:0] = 2'($urandom);
      if (op_cls[idx] == C_BR) op[4:0] = 5'($urandom);
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
      if (!bus.in_ready) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
         return;
      end
      bus.in_op = op; bus.in_rd = rd; bus.in_rn = rn; bus.in_rm = rm; bus.in_imm = imm;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      model(op_cls[idx], op, rd, rn, rm, imm, inst, fits);
      if (!CHK_EN || fits) begin
         sb_q.push_back('{addr: m_addr, inst: inst});
         m_addr = m_addr + 64'(STEP);
      end else begin
         m_err = 1'b1;
         if (m_cnt < 255) m_cnt++;
      end
      check("err", 64'(bus.err), 64'(m_err));
      check("err_cnt", 64'(bus.err_cnt), 64'(m_cnt));
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      check("drain", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_addr = BASE; m_err = 1'b0; m_cnt = 0;
   endtask

   // out_ready driver
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0: bus.out_ready = 1'($urandom);
            1: bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: a word is consumed on any edge where out_valid & out_ready hold without clear/reset.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (rst_n && !bus.clear && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_word: got %0h expected none", bus.out_inst);
            end else begin
               e = sb_q.pop_front();
               check("out_addr", bus.out_addr, e.addr);
               check("out_inst", 64'(bus.out_inst), 64'(e.inst));
            end
         end
      end
   end

   initial begin
      logic [31:0] t;
      bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0;
      bus.in_rn = '0; bus.in_rm = '0; bus.in_imm = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_inst", 64'(bus.out_inst), 64'd0);
      check("rst_out_addr", bus.out_addr, BASE);
      check("rst_err", 64'(bus.err), 64'd0);
      check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // ADDI rd=1 rn=2 imm=-5, held so latency and placement are visible
      rdy_mode = 1;
      send(5, -64'sd5, 5'd1, 5'd2, 5'd0);
      check("addi_valid_lat", 64'(bus.out_valid), 64'd1);
      t = bus.out_inst;
      check("addi_imm_field", 64'(t[20:10]), 64'h7FB);
      check("addi_addr", bus.out_addr, BASE);
      rdy_mode = 2;
      wait_drain();

      // LDUR 255 then 256
      send(11, 64'd255, 5'd3, 5'd4, 5'd0);
      send(11, 64'd256, 5'd3, 5'd4, 5'd0);
      wait_drain();
      @(negedge clk);
      check("ldur_addr", bus.out_addr, m_addr);

      // B -1 stalled five cycles
      rdy_mode = 1;
      send(16, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #2;
         check("stall_inst", 64'(bus.out_inst), 64'(sb_q[0].inst));
         check("stall_addr", bus.out_addr, sb_q[0].addr);
         check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         check("stall_valid", 64'(bus.out_valid), 64'd1);
      end
      t = bus.out_inst;
      check("b_imm_field", 64'(t[25:0]), 64'h3FFFFFF);
      rdy_mode = 2;
      wait_drain();
      @(negedge clk);
      check("b_addr_step", bus.out_addr, m_addr);

      // clear during EMIT, after an error has been logged (when checking is on)
      send(6, 64'd5000, 5'd7, 5'd8, 5'd0);
      wait_drain();
      rdy_mode = 1;
      send(9, 64'd12, 5'd9, 5'd10, 5'd0);
      @(negedge clk);
      bus.clear = 1'b1;
      model_reset();
      @(posedge clk); #1;
      check("clr_out_valid", 64'(bus.out_valid), 64'd0);
      check("clr_in_ready", 64'(bus.in_ready), 64'd0);
      check("clr_addr", bus.out_addr, BASE);
      check("clr_err", 64'(bus.err), 64'd0);
      check("clr_err_cnt", 64'(bus.err_cnt), 64'd0);
      @(negedge clk); bus.clear = 1'b0;
      rdy_mode = 2;
      send(7, 64'd33, 5'd11, 5'd12, 5'd0);
      wait_drain();

      // randomized traffic with random backpressure
      rdy_mode = 0;
      for (int i = 0; i < 200; i++) begin
         int idx;
         idx = $urandom_range(0, 19);
         send(idx, pick_imm(op_cls[idx]), 5'($urandom), 5'($urandom), 5'($urandom));
      end
      rdy_mode = 2;
      wait_drain();

      // reset mid-EMIT
      rdy_mode = 1;
      send(19, 64'h1234, 5'd5, 5'd0, 5'd0);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("mid_rst_inst", 64'(bus.out_inst), 64'd0);
      check("mid_rst_addr", bus.out_addr, BASE);
      check("mid_rst_err", 64'(bus.err), 64'd0);
      check("mid_rst_err_cnt", 64'(bus.err_cnt), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) send(11, 64'd256, 5'd1, 5'd1, 5'd0);
      wait_drain();
      @(negedge clk);
      check("sat_err_cnt", 64'(bus.err_cnt), 64'(m_cnt));
      check("final_valid", 64'(bus.out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
